hamming74_decoder: RTL
======================

Name: hamming74_decoder

Overview:
- Receive-side counterpart of the team's Hamming(7,4) encoder.
- Accepts 7-bit codewords in p1 p2 d3 p3 d2 d1 d0 order, computes the syndrome, corrects any single-bit error and returns the 4-bit data word.
- Two-stage pipeline with valid/ready handshake on both sides, plus a saturating corrected-error counter for link-quality monitoring.

Parameters:
CNT_W, 8, width of corrected-error counter err_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  codeword on in_codeword is valid
in_ready  output  1  decoder accepts codeword this cycle
in_codeword  input  7  {p1,p2,d3,p3,d2,d1,d0}, bit 6 = p1 (Hamming position 1), bit 0 = d0 (position 7)
out_valid  output  1  out_data/out_err/out_syndrome valid
out_ready  input  1  downstream accepts output this cycle
out_data  output  4  corrected data {d3,d2,d1,d0}
out_err  output  1  1 = single-bit error detected and corrected
out_syndrome  output  3  {s3,s2,s1} = Hamming position (1..7) of the flipped bit, 0 = clean
cnt_clr  input  1  synchronous clear of err_count
err_count  output  CNT_W  number of delivered words with out_err=1, saturating

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high. On reset: s1_valid=0, out_valid=0, out_data=0, out_err=0, out_syndrome=0, err_count=0. in_ready is 1 in the first cycle after reset.
- Syndrome, from cw = in_codeword:
  - s1 = cw[6]^cw[4]^cw[2]^cw[0]
  - s2 = cw[5]^cw[4]^cw[1]^cw[0]
  - s3 = cw[3]^cw[2]^cw[1]^cw[0]
  - pos = {s3,s2,s1}
- Correction: if pos != 0, invert cw[7-pos]. Data = {cw[4],cw[2],cw[1],cw[0]} of the corrected word.
- Pipeline:
  - Stage 1 registers codeword and syndrome on input handshake.
  - Stage 2 registers corrected data, out_err=(pos!=0) and out_syndrome.
  - Latency: 2 cycles from accepted input to out_valid.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, both stages hold all contents; outputs stay stable while out_valid=1 and out_ready=0.
  - When advance=1, stage 2 loads stage 1 (out_valid <= s1_valid) and stage 1 loads the input (s1_valid <= in_valid).
- Throughput: 1 word/cycle with out_ready held high. Back-to-back words stream with no bubbles.
- Output handshake: a word is delivered on the cycle where out_valid && out_ready.
- err_count:
  - Increments by 1 on each delivered word with out_err=1.
  - Holds at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets it to 0 next cycle. cnt_clr together with an increment gives 0 (clear wins).
  - cnt_clr has no effect on the pipeline.
- Limitation: double-bit errors are not detected. They miscorrect as a single error; this is documented, not flagged.
- Reset mid-operation: all in-flight words are discarded with no output. err_count=0.
- No X propagation: out_data/out_syndrome are registered only on advance, so they hold their previous values when out_valid=0.

Test Plan:
1. Reset, then in_codeword=7'b0110011 (data 4'b1011) with out_ready=1 -> 2 cycles later out_valid=1, out_data=4'b1011, out_err=0, out_syndrome=0, err_count stays 0.
2. in_codeword=7'b0110010 (d0 flipped) -> out_data=4'b1011, out_err=1, out_syndrome=3'd7, err_count=1 after delivery. Then 7'b1110011 (p1 flipped) -> out_data=4'b1011, out_syndrome=3'd1, err_count=2.
3. All 16 data words, each clean and with each of the 7 single-bit flips, streamed back-to-back with out_ready=1 -> 128 outputs in order on consecutive cycles, data always correct, out_syndrome equals the flipped position, err_count=112 (CNT_W=8).
4. Backpressure: stream 4 words, drop out_ready for 3 cycles mid-stream -> in_ready=0 during stall, outputs held stable, no loss or duplication, order preserved.
5. CNT_W=2: deliver 5 erroneous words -> err_count saturates at 3. Assert cnt_clr on the same cycle as a delivered erroneous word -> err_count=0 next cycle.
6. Assert reset with 2 words in flight -> no out_valid afterwards until new input, err_count=0, in_ready=1.

Source files
------------

// File: rtl/hamming74_decoder.sv
// hamming74_decoder: two-stage Hamming(7,4) single-error-correcting decoder
// with a global-stall valid/ready pipeline and a saturating corrected-error counter.
module hamming74_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);
  logic             w_adv;
  logic [2:0]       w_syn;
  logic [6:0]       w_fix;
  logic             r_s1_valid;
  logic [6:0]       r_s1_cw;
  logic [2:0]       r_s1_syn;
  logic             r_out_valid;
  logic [3:0]       r_out_data;
  logic             r_out_err;
  logic [2:0]       r_out_syn;
  logic [CNT_W-1:0] r_cnt;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_syn    = {^in_codeword[3:0],
                     in_codeword[5] ^ in_codeword[4] ^ in_codeword[1] ^ in_codeword[0],
                     in_codeword[6] ^ in_codeword[4] ^ in_codeword[2] ^ in_codeword[0]};
  // Hamming position p lives at codeword bit 7-p
  assign w_fix    = r_s1_cw ^ ((r_s1_syn == 3'd0) ? 7'd0 : (7'h40 >> (r_s1_syn - 3'd1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_cw     <= '0;
      r_s1_syn    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_out_syn   <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_out_valid <= r_s1_valid;
      if (in_valid) begin
        r_s1_cw  <= in_codeword;
        r_s1_syn <= w_syn;
      end
      if (r_s1_valid) begin
        r_out_data <= {w_fix[4], w_fix[2], w_fix[1], w_fix[0]};
        r_out_err  <= r_s1_syn != 3'd0;
        r_out_syn  <= r_s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr)
      r_cnt <= '0;
    else if (r_out_valid && out_ready && r_out_err && r_cnt != '1)
      r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_err      = r_out_err;
  assign out_syndrome = r_out_syn;
  assign err_count    = r_cnt;
endmodule
